dafx_osc_sweep_ctrl: RTL and testbench
======================================

// Module: dafx_osc_sweep_ctrl
// PURPOSE
//  AXI4-Lite write-only master that sequences oscillator frequency sweeps. It steps the osc0 frequency
//  control register from a start value to an end value, holding each value for a programmed number of
//  cycles. Sits beside the CPU on the DAFX register-bank interconnect.
//  Provides glitch-free, CPU-free frequency ramps for audio test and effects.
// PARAMETERS
//  AXI_ADDR_WIDTH_P  16                        AXI address width
//  AXI_DATA_WIDTH_P  32                        AXI data width; wstrb = AXI_DATA_WIDTH_P/8
//  N_BITS_P          32                        frequency word width (<= AXI_DATA_WIDTH_P)
//  HOLD_WIDTH_P      24                        hold-counter width
//  FREQ_ADDR_P       DAFX_OSC0_FREQUENCY_ADDR  target register address
// PORTS
//  clk                   in   1                 clock
//  rst                   in   1                 synchronous reset, active-high
//  cmd_sweep_start       in   1                 1-cycle pulse: start sweep
//  cmd_sweep_stop        in   1                 1-cycle pulse: stop sweep
//  cr_sweep_start_freq   in   N_BITS_P          first frequency written
//  cr_sweep_end_freq     in   N_BITS_P          last frequency written
//  cr_sweep_step         in   N_BITS_P          unsigned step magnitude
//  cr_sweep_hold_cycles  in   HOLD_WIDTH_P      idle cycles between write response and next write
//  awaddr                out  AXI_ADDR_WIDTH_P  write address
//  awvalid / awready     out / in  1            write address handshake
//  wdata                 out  AXI_DATA_WIDTH_P  frequency, zero-extended
//  wstrb                 out  AXI_DATA_WIDTH_P/8  all ones
//  wvalid / wready       out / in  1            write data handshake
//  bresp                 in   2                 write response
//  bvalid / bready       in / out  1            write response handshake
//  sr_sweep_busy         out  1                 high from start until return to IDLE
//  sr_sweep_cur_freq     out  N_BITS_P          last frequency whose write was issued
//  sr_sweep_error        out  1                 sticky; set on bresp != 0
//  irq_sweep_done        out  1                 1-cycle pulse when a sweep completes normally
// BEHAVIOUR
//  Reset values: awvalid, wvalid, bready, busy, error, irq = 0; awaddr = FREQ_ADDR_P; wdata, cur_freq = 0.
//  cr_* inputs are sampled only on an accepted start. Direction = up if end >= start, else down.
//  FSM states: IDLE, WRITE, RESP, HOLD, DONE.
//  IDLE: on cmd_sweep_start go to WRITE with cur = start, error cleared, busy = 1 in the next cycle.
//  WRITE: awvalid and wvalid rise together. Each drops on its own ready; both may complete in the same
//   or different cycles. Valids are never withdrawn before their handshake completes. When both are
//   done, go to RESP.
//  RESP: bready = 1. On bvalid:
//   - bresp != 0: set error, go to IDLE (no irq).
//   - stop pending: go to IDLE.
//   - cur == end: go to DONE.
//   - else: go to HOLD.
//  HOLD: count hold_cycles (0 means go to WRITE immediately). Then cur = next; go to WRITE.
//  next: computed in N_BITS_P+1 bits; clamp to end on overshoot or wrap. step == 0 forces next = end.
//  DONE: irq_sweep_done = 1 for one cycle; go to IDLE.
//  Stop: latched as pending in any non-IDLE state.
//   - In HOLD: go to IDLE on the next cycle.
//   - In WRITE/RESP: the outstanding transaction completes, then go to IDLE. No irq is raised.
//  cmd_sweep_start while busy is ignored. Start and stop in the same cycle in IDLE: start wins, stop is pending.
//  start == end: exactly one write, then DONE.
//  rst mid-transaction drops valids immediately; the slave shares the same reset source.
// CONFIGURATION
//  DAFX_SWEEP_PINGPONG_EN defined:
//   - On reaching end (instead of DONE), swap the start/end roles and reverse direction, then go to HOLD.
//   - Repeat indefinitely until stop or error. irq_sweep_done is never pulsed.
//   - Endpoint values are written once per turn, not twice.
//  DAFX_SWEEP_PINGPONG_EN undefined: single pass; behaviour as above.
// TESTING
//  1. start=100, end=130, step=10, hold=4, ready always 1 -> writes 100,110,120,130; >=4 cycles between
//     bvalid and next awvalid; one irq; busy falls after.
//  2. start=130, end=100, step=20 -> writes 130,110,100 (clamped); irq once.
//  3. awready delayed 3 cycles after wready, bvalid delayed 5 -> valids held until handshake;
//     exactly one write per value; wstrb = 4'hF.
//  4. Stop pulse mid-HOLD after value 110, and separately stop during WRITE -> no further writes after
//     the current response; busy = 0; no irq.
//  5. bresp = 2'b10 on second write -> error = 1, IDLE, no irq. Next start clears error.
//  6. PINGPONG_EN: start=0, end=20, step=10 -> writes 0,10,20,10,0,10... until stop; irq stays 0.

Source files
------------

// File: rtl/dafx_osc_sweep_ctrl_if.sv
// rtl/dafx_osc_sweep_ctrl_if.sv - AXI4-Lite write-channel bundle between the sweep master and the register bank
//
// Signals:
//   awaddr/awvalid/awready   write address channel
//   wdata/wstrb/wvalid/wready write data channel
//   bresp/bvalid/bready       write response channel
// Modports: master (sweep controller side), slave (register-bank side).

interface dafx_osc_sweep_ctrl_if #(
   parameter int AXI_ADDR_WIDTH_P = 16,
   parameter int AXI_DATA_WIDTH_P = 32
);
   logic [AXI_ADDR_WIDTH_P-1:0]   awaddr;
   logic                          awvalid;
   logic                          awready;
   logic [AXI_DATA_WIDTH_P-1:0]   wdata;
   logic [AXI_DATA_WIDTH_P/8-1:0] wstrb;
   logic                          wvalid;
   logic                          wready;
   logic [1:0]                    bresp;
   logic                          bvalid;
   logic                          bready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/dafx_osc_sweep_ctrl.sv
// rtl/dafx_osc_sweep_ctrl.sv - AXI4-Lite write master that ramps the osc0 frequency register
//
// Steps the frequency register from a start value to an end value, waiting a
// programmed number of idle cycles after each write response.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_sweep_start/stop     single-cycle command pulses
//   cr_sweep_start_freq      first frequency written
//   cr_sweep_end_freq        last frequency written
//   cr_sweep_step            unsigned step magnitude
//   cr_sweep_hold_cycles     idle cycles between write response and next write
//   axi                      AXI4-Lite write channels (master modport)
//   sr_sweep_busy            high from accepted start until back in IDLE
//   sr_sweep_cur_freq        last frequency whose write was issued
//   sr_sweep_error           sticky error flag, set on a non-OKAY response
//   irq_sweep_done           one-cycle pulse on normal completion
//
// Build option: DAFX_SWEEP_PINGPONG_EN - bounce between the endpoints
// indefinitely instead of finishing after one pass.

module dafx_osc_sweep_ctrl #(
   parameter int AXI_ADDR_WIDTH_P = 16,
   parameter int AXI_DATA_WIDTH_P = 32,
   parameter int N_BITS_P         = 32,
   parameter int HOLD_WIDTH_P     = 24,
   // Default location of the osc0 frequency register in the DAFX bank.
   parameter logic [AXI_ADDR_WIDTH_P-1:0] FREQ_ADDR_P = AXI_ADDR_WIDTH_P'('h0040)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_sweep_start,
   input  logic                    cmd_sweep_stop,
   input  logic [N_BITS_P-1:0]     cr_sweep_start_freq,
   input  logic [N_BITS_P-1:0]     cr_sweep_end_freq,
   input  logic [N_BITS_P-1:0]     cr_sweep_step,
   input  logic [HOLD_WIDTH_P-1:0] cr_sweep_hold_cycles,
   dafx_osc_sweep_ctrl_if.master   axi,
   output logic                    sr_sweep_busy,
   output logic [N_BITS_P-1:0]     sr_sweep_cur_freq,
   output logic                    sr_sweep_error,
   output logic                    irq_sweep_done
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      RESP,
      HOLD,
      DONE
   } state_t;

   state_t                      state;
   logic [N_BITS_P-1:0]         cur;
   logic [N_BITS_P-1:0]         end_r;
   logic [N_BITS_P-1:0]         step_r;
   logic [HOLD_WIDTH_P-1:0]     hold_r;
   logic [HOLD_WIDTH_P-1:0]     hold_cnt;
   logic                        dir_up;
   logic                        stop_pend;
   logic                        awvalid_r;
   logic                        wvalid_r;
   logic                        bready_r;
   logic [AXI_DATA_WIDTH_P-1:0] wdata_r;
   logic                        busy_r;
   logic                        error_r;
   logic                        irq_r;
`ifdef DAFX_SWEEP_PINGPONG_EN
   logic [N_BITS_P-1:0]         start_r;
`endif

   // Next frequency, computed one bit wider so that carry/borrow exposes a
   // wrap. Anything that would pass the end value, wrap, or a zero step
   // lands exactly on the end value.
   logic [N_BITS_P:0]   sum_up;
   logic [N_BITS_P:0]   sum_dn;
   logic [N_BITS_P-1:0] next_freq;

   always_comb begin
      sum_up    = {1'b0, cur} + {1'b0, step_r};
      sum_dn    = {1'b0, cur} - {1'b0, step_r};
      next_freq = end_r;
      if (step_r != '0) begin
         if (dir_up) begin
            if (!sum_up[N_BITS_P] && (sum_up[N_BITS_P-1:0] < end_r))
               next_freq = sum_up[N_BITS_P-1:0];
         end else begin
            if (!sum_dn[N_BITS_P] && (sum_dn[N_BITS_P-1:0] > end_r))
               next_freq = sum_dn[N_BITS_P-1:0];
         end
      end
   end

   wire aw_done  = !awvalid_r || axi.awready;
   wire w_done   = !wvalid_r  || axi.wready;
   wire stop_now = stop_pend  || cmd_sweep_stop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur       <= '0;
         end_r     <= '0;
         step_r    <= '0;
         hold_r    <= '0;
         hold_cnt  <= '0;
         dir_up    <= 1'b1;
         stop_pend <= 1'b0;
         awvalid_r <= 1'b0;
         wvalid_r  <= 1'b0;
         bready_r  <= 1'b0;
         wdata_r   <= '0;
         busy_r    <= 1'b0;
         error_r   <= 1'b0;
         irq_r     <= 1'b0;
`ifdef DAFX_SWEEP_PINGPONG_EN
         start_r   <= '0;
`endif
      end else begin
         irq_r <= 1'b0;
         // Later assignments in the case below override this when the
         // sweep returns to IDLE in the same cycle.
         if ((state != IDLE) && cmd_sweep_stop)
            stop_pend <= 1'b1;

         case (state)
            IDLE: begin
               if (cmd_sweep_start) begin
                  cur       <= cr_sweep_start_freq;
                  end_r     <= cr_sweep_end_freq;
                  step_r    <= cr_sweep_step;
                  hold_r    <= cr_sweep_hold_cycles;
                  dir_up    <= (cr_sweep_end_freq >= cr_sweep_start_freq);
`ifdef DAFX_SWEEP_PINGPONG_EN
                  start_r   <= cr_sweep_start_freq;
`endif
                  error_r   <= 1'b0;
                  busy_r    <= 1'b1;
                  stop_pend <= cmd_sweep_stop;
                  awvalid_r <= 1'b1;
                  wvalid_r  <= 1'b1;
                  wdata_r   <= AXI_DATA_WIDTH_P'(cr_sweep_start_freq);
                  state     <= WRITE;
               end
            end

            WRITE: begin
               if (axi.awready) awvalid_r <= 1'b0;
               if (axi.wready)  wvalid_r  <= 1'b0;
               if (aw_done && w_done) begin
                  bready_r <= 1'b1;
                  state    <= RESP;
               end
            end

            RESP: begin
               if (axi.bvalid) begin
                  bready_r <= 1'b0;
                  if (axi.bresp != 2'b00) begin
                     error_r   <= 1'b1;
                     busy_r    <= 1'b0;
                     stop_pend <= 1'b0;
                     state     <= IDLE;
                  end else if (stop_now) begin
                     busy_r    <= 1'b0;
                     stop_pend <= 1'b0;
                     state     <= IDLE;
                  end else if (cur == end_r) begin
`ifdef DAFX_SWEEP_PINGPONG_EN
                     // Turn around: the value just written becomes the new
                     // start, so it is not written again on the way back.
                     start_r  <= end_r;
                     end_r    <= start_r;
                     dir_up   <= !dir_up;
                     hold_cnt <= HOLD_WIDTH_P'(1);
                     state    <= HOLD;
`else
                     irq_r    <= 1'b1;
                     state    <= DONE;
`endif
                  end else if (hold_r == '0) begin
                     cur       <= next_freq;
                     wdata_r   <= AXI_DATA_WIDTH_P'(next_freq);
                     awvalid_r <= 1'b1;
                     wvalid_r  <= 1'b1;
                     state     <= WRITE;
                  end else begin
                     hold_cnt <= HOLD_WIDTH_P'(1);
                     state    <= HOLD;
                  end
               end
            end

            HOLD: begin
               if (stop_now) begin
                  busy_r    <= 1'b0;
                  stop_pend <= 1'b0;
                  state     <= IDLE;
               end else if (hold_cnt >= hold_r) begin
                  cur       <= next_freq;
                  wdata_r   <= AXI_DATA_WIDTH_P'(next_freq);
                  awvalid_r <= 1'b1;
                  wvalid_r  <= 1'b1;
                  state     <= WRITE;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_WIDTH_P'(1);
               end
            end

            DONE: begin
               busy_r    <= 1'b0;
               stop_pend <= 1'b0;
               state     <= IDLE;
            end

            default: begin
               awvalid_r <= 1'b0;
               wvalid_r  <= 1'b0;
               bready_r  <= 1'b0;
               busy_r    <= 1'b0;
               stop_pend <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign axi.awaddr        = FREQ_ADDR_P;
   assign axi.awvalid       = awvalid_r;
   assign axi.wdata         = wdata_r;
   assign axi.wstrb         = '1;
   assign axi.wvalid        = wvalid_r;
   assign axi.bready        = bready_r;
   assign sr_sweep_busy     = busy_r;
   assign sr_sweep_cur_freq = cur;
   assign sr_sweep_error    = error_r;
   assign irq_sweep_done    = irq_r;

endmodule

// File: tb/tb_dafx_osc_sweep_ctrl.sv
// tb/tb_dafx_osc_sweep_ctrl.sv - directed bench for dafx_osc_sweep_ctrl with a delay-programmable AXI4-Lite slave
module tb_dafx_osc_sweep_ctrl;

   localparam logic [15:0] ADDR = 16'h0040;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_start;
   logic        cmd_stop;
   logic [31:0] c_start;
   logic [31:0] c_end;
   logic [31:0] c_step;
   logic [23:0] c_hold;
   logic        busy;
   logic [31:0] cur_freq;
   logic        error;
   logic        irq;

   always #5 clk = ~clk;

   dafx_osc_sweep_ctrl_if #(.AXI_ADDR_WIDTH_P(16), .AXI_DATA_WIDTH_P(32)) axi ();

   dafx_osc_sweep_ctrl #(
      .AXI_ADDR_WIDTH_P(16),
      .AXI_DATA_WIDTH_P(32),
      .N_BITS_P(32),
      .HOLD_WIDTH_P(24),
      .FREQ_ADDR_P(ADDR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_sweep_start(cmd_start),
      .cmd_sweep_stop(cmd_stop),
      .cr_sweep_start_freq(c_start),
      .cr_sweep_end_freq(c_end),
      .cr_sweep_step(c_step),
      .cr_sweep_hold_cycles(c_hold),
      .axi(axi),
      .sr_sweep_busy(busy),
      .sr_sweep_cur_freq(cur_freq),
      .sr_sweep_error(error),
      .irq_sweep_done(irq)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // slave model state and observations
   int          aw_dly = 0, w_dly = 0, b_dly = 0, err_idx = -1;
   int          cyc = 0;
   logic [31:0] wlog[$];
   logic [31:0] exp_q[$];
   int          aw_cnt, b_cnt, irq_cnt, min_gap, last_b_cyc, withdraw_cnt, strb_bad, addr_bad;
   int          aw_wait, w_wait, b_wait;
   bit          aw_got, w_got;
   bit          prev_awv, prev_wv, prev_aw_fire, prev_w_fire, prev_b_fire;

   task automatic clear_stats();
      wlog.delete();
      aw_cnt = 0; b_cnt = 0; irq_cnt = 0; min_gap = 1000000; last_b_cyc = -1;
      withdraw_cnt = 0; strb_bad = 0; addr_bad = 0;
   endtask

   // Readies/bvalid change only at negedge; whatever is both-high at a
   // negedge is exactly the handshake taken at the following posedge.
   initial begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      clear_stats();
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
            aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
            prev_awv = 0; prev_wv = 0; prev_aw_fire = 0; prev_w_fire = 0; prev_b_fire = 0;
         end else begin
            if (irq) irq_cnt++;
            if (prev_awv && !prev_aw_fire && !axi.awvalid) withdraw_cnt++;
            if (prev_wv && !prev_w_fire && !axi.wvalid) withdraw_cnt++;
            if (prev_b_fire) begin
               axi.bvalid = 1'b0; axi.bresp = 2'b00; aw_got = 0; w_got = 0;
            end
            if (prev_aw_fire) aw_got = 1;
            if (prev_w_fire) w_got = 1;
            if (axi.awvalid && !prev_awv && last_b_cyc >= 0 && (cyc - last_b_cyc) < min_gap)
               min_gap = cyc - last_b_cyc;
            if (axi.awvalid && !aw_got) begin
               axi.awready = (aw_wait >= aw_dly); aw_wait++;
            end else begin
               axi.awready = 1'b0; aw_wait = 0;
            end
            if (axi.wvalid && !w_got) begin
               axi.wready = (w_wait >= w_dly); w_wait++;
            end else begin
               axi.wready = 1'b0; w_wait = 0;
            end
            if (aw_got && w_got && !axi.bvalid) begin
               if (b_wait >= b_dly) begin
                  axi.bvalid = 1'b1;
                  axi.bresp  = (wlog.size() == err_idx) ? 2'b10 : 2'b00;
                  b_wait = 0;
               end else begin
                  b_wait++;
               end
            end
            prev_aw_fire = axi.awvalid && axi.awready;
            prev_w_fire  = axi.wvalid && axi.wready;
            prev_b_fire  = axi.bvalid && axi.bready;
            if (prev_aw_fire) begin
               aw_cnt++;
               if (axi.awaddr !== ADDR) addr_bad++;
            end
            if (prev_w_fire) begin
               wlog.push_back(axi.wdata);
               if (axi.wstrb !== 4'hF) strb_bad++;
            end
            if (prev_b_fire) begin
               b_cnt++;
               last_b_cyc = cyc;
            end
            prev_awv = axi.awvalid;
            prev_wv  = axi.wvalid;
         end
      end
   end

   task automatic start_sweep(input logic [31:0] s, input logic [31:0] e,
                              input logic [31:0] st, input logic [23:0] h, input bit with_stop);
      c_start = s; c_end = e; c_step = st; c_hold = h;
      clear_stats();
      cmd_start = 1'b1;
      cmd_stop  = with_stop;
      @(negedge clk);
      cmd_start = 1'b0;
      cmd_stop  = 1'b0;
   endtask

   task automatic pulse_stop();
      cmd_stop = 1'b1;
      @(negedge clk);
      cmd_stop = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("%s_idle_timeout", tag), busy, 1'b0);
      repeat (4) @(negedge clk);
   endtask

   task automatic check_writes(input string tag);
      check($sformatf("%s_nwrites", tag), wlog.size(), exp_q.size());
      check($sformatf("%s_naw", tag), aw_cnt, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < wlog.size())
            check($sformatf("%s_w%0d", tag, i), wlog[i], exp_q[i]);
      check($sformatf("%s_addr", tag), addr_bad, 0);
      check($sformatf("%s_strb", tag), strb_bad, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0;
      c_start = '0; c_end = '0; c_step = '0; c_hold = '0;
      repeat (3) @(negedge clk);
      check("rst_awvalid", axi.awvalid, 1'b0);
      check("rst_wvalid", axi.wvalid, 1'b0);
      check("rst_bready", axi.bready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_irq", irq, 1'b0);
      check("rst_cur", cur_freq, 32'd0);
      check("rst_wdata", axi.wdata, 32'd0);
      check("rst_awaddr", axi.awaddr, ADDR);
      rst = 1'b0;
      repeat (2) @(negedge clk);

`ifdef DAFX_SWEEP_PINGPONG_EN
      // bounce 0 -> 20 -> 0 ... until stopped, endpoints written once per turn
      begin
         int n = 0;
         start_sweep(0, 20, 10, 1, 1'b0);
         while (wlog.size() < 6 && n < 500) begin @(negedge clk); n++; end
         check("pp_reach6", wlog.size() >= 6, 1'b1);
         pulse_stop();
         wait_idle("pp", 200);
         exp_q = '{0, 10, 20, 10, 0, 10};
         for (int i = 0; i < 6; i++)
            if (i < wlog.size()) check($sformatf("pp_w%0d", i), wlog[i], exp_q[i]);
         check("pp_irq", irq_cnt, 0);
         check("pp_busy", busy, 1'b0);
      end
`else
      // 1: upward ramp, exact landing on end
      start_sweep(100, 130, 10, 4, 1'b0);
      check("t1_busy_rise", busy, 1'b1);
      wait_idle("t1", 500);
      exp_q = '{100, 110, 120, 130};
      check_writes("t1");
      check("t1_irq", irq_cnt, 1);
      check("t1_gap", min_gap >= 5, 1'b1);
      check("t1_cur", cur_freq, 32'd130);
      check("t1_err", error, 1'b0);

      // 2: downward ramp, last step clamped
      start_sweep(130, 100, 20, 2, 1'b0);
      wait_idle("t2", 500);
      exp_q = '{130, 110, 100};
      check_writes("t2");
      check("t2_irq", irq_cnt, 1);
      check("t2_cur", cur_freq, 32'd100);

      // 3: slow awready and bvalid, zero hold
      aw_dly = 3; w_dly = 0; b_dly = 5;
      start_sweep(5, 7, 1, 0, 1'b0);
      wait_idle("t3", 500);
      exp_q = '{5, 6, 7};
      check_writes("t3");
      check("t3_withdraw", withdraw_cnt, 0);
      check("t3_irq", irq_cnt, 1);
      aw_dly = 0; b_dly = 0;

      // 4a: stop while holding after 110
      begin
         int n = 0;
         start_sweep(100, 130, 10, 20, 1'b0);
         while (b_cnt < 2 && n < 200) begin @(negedge clk); n++; end
         check("t4a_reach", b_cnt, 2);
         repeat (3) @(negedge clk);
         pulse_stop();
         check("t4a_busy_next", busy, 1'b0);
         repeat (40) @(negedge clk);
         exp_q = '{100, 110};
         check_writes("t4a");
         check("t4a_irq", irq_cnt, 0);
      end

      // 4b: stop while the first write is still waiting for awready
      aw_dly = 3;
      start_sweep(100, 130, 10, 2, 1'b0);
      check("t4b_inwrite", axi.awvalid, 1'b1);
      pulse_stop();
      wait_idle("t4b", 200);
      repeat (20) @(negedge clk);
      exp_q = '{100};
      check_writes("t4b");
      check("t4b_irq", irq_cnt, 0);
      check("t4b_busy", busy, 1'b0);
      aw_dly = 0;

      // 5: slave error on second write, then a clean single-value sweep
      err_idx = 2;
      start_sweep(100, 130, 10, 1, 1'b0);
      wait_idle("t5", 300);
      exp_q = '{100, 110};
      check_writes("t5");
      check("t5_error", error, 1'b1);
      check("t5_irq", irq_cnt, 0);
      err_idx = -1;
      start_sweep(50, 50, 10, 3, 1'b0);
      check("t5b_err_clr", error, 1'b0);
      wait_idle("t5b", 200);
      exp_q = '{50};
      check_writes("t5b");
      check("t5b_irq", irq_cnt, 1);

      // 7: start and stop in the same IDLE cycle -> one write, no irq
      start_sweep(200, 300, 10, 1, 1'b1);
      wait_idle("t7", 200);
      exp_q = '{200};
      check_writes("t7");
      check("t7_irq", irq_cnt, 0);

      // 8: upward overshoot clamp and zero step
      start_sweep(0, 25, 10, 1, 1'b0);
      wait_idle("t8", 300);
      exp_q = '{0, 10, 20, 25};
      check_writes("t8");
      start_sweep(10, 40, 0, 0, 1'b0);
      wait_idle("t8z", 300);
      exp_q = '{10, 40};
      check_writes("t8z");
      check("t8z_irq", irq_cnt, 1);

      // 9: downward wrap below zero clamps to end
      start_sweep(15, 3, 10, 0, 1'b0);
      wait_idle("t9", 300);
      exp_q = '{15, 5, 3};
      check_writes("t9");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
